// File: rtl/ctrl_pipe_if.sv
// ID-slot inputs and EX/MEM/WB control outputs of the control pipeline.
// The design sits on the slave side; the driver of the ID slot is the master.
interface ctrl_pipe_if #(
  parameter int ALUOP_W = 2,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
);
  logic [6:0]         op_i;
  logic [RA_W-1:0]    rs1_i;
  logic [RA_W-1:0]    rs2_i;
  logic [RA_W-1:0]    rd_i;
  logic               valid_i;
  logic               flush_i;
  logic               clr_cnt_i;
  logic               stall_o;
  logic               id_branch_o;
  logic               ex_valid_o;
  logic [ALUOP_W-1:0] ex_aluop_o;
  logic               ex_alusrc_o;
  logic               ex_illegal_o;
  logic               mem_valid_o;
  logic               mem_memread_o;
  logic               mem_memwrite_o;
  logic               mem_regwrite_o;
  logic [RA_W-1:0]    mem_rd_o;
  logic               wb_valid_o;
  logic               wb_regwrite_o;
  logic               wb_memtoreg_o;
  logic [RA_W-1:0]    wb_rd_o;
  logic [CNT_W-1:0]   retired_o;
  logic [CNT_W-1:0]   stalls_o;

  modport slave (
    input  op_i, rs1_i, rs2_i, rd_i, valid_i, flush_i, clr_cnt_i,
    output stall_o, id_branch_o, ex_valid_o, ex_aluop_o, ex_alusrc_o, ex_illegal_o,
           mem_valid_o, mem_memread_o, mem_memwrite_o, mem_regwrite_o, mem_rd_o,
           wb_valid_o, wb_regwrite_o, wb_memtoreg_o, wb_rd_o, retired_o, stalls_o
  );

  modport master (
    output op_i, rs1_i, rs2_i, rd_i, valid_i, flush_i, clr_cnt_i,
    input  stall_o, id_branch_o, ex_valid_o, ex_aluop_o, ex_alusrc_o, ex_illegal_o,
           mem_valid_o, mem_memread_o, mem_memwrite_o, mem_regwrite_o, mem_rd_o,
           wb_valid_o, wb_regwrite_o, wb_memtoreg_o, wb_rd_o, retired_o, stalls_o
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Decode / hazard / control pipeline for a 5-stage RV32 subset core:
// decodes in ID, carries the control bundle through EX, MEM and WB.
module ctrl_pipe #(
  parameter int ALUOP_W = 2,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  ctrl_pipe_if.slave bus
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               illegal;
    logic [RA_W-1:0]    rd;
  } ex_t;

  typedef struct packed {
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            illegal;
    logic [RA_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic            illegal;
    logic [RA_W-1:0] rd;
  } wb_t;

  ex_t              dec;
  logic             uses_rs2;
  logic             hazard;
  logic             bubble;
  logic             vld_p0, vld_p1, vld_p2;
  ex_t              ex_p0;
  mem_t             mem_p1;
  wb_t              wb_p2;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] stalls_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    return (inc && (cnt != {CNT_W{1'b1}})) ? cnt + CNT_W'(1) : cnt;
  endfunction

  always_comb begin
    dec      = '0;
    uses_rs2 = 1'b0;
    case (bus.op_i)
      OP_R:   begin dec.aluop = ALUOP_W'(2'b10); dec.regwrite = 1'b1; uses_rs2 = 1'b1; end
      OP_I:   begin dec.aluop = ALUOP_W'(2'b11); dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      OP_LW:  begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
      end
      OP_SW:  begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; uses_rs2 = 1'b1; end
      OP_BEQ: begin dec.aluop = ALUOP_W'(2'b01); uses_rs2 = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
    // A stage with no register write never exposes a destination.
    dec.rd = dec.regwrite ? bus.rd_i : '0;
  end

  // Load-use hazard: the load in EX cannot forward to the ID instruction in time.
  assign hazard = vld_p0 & ex_p0.memread & (ex_p0.rd != '0) & bus.valid_i &
                  ((ex_p0.rd == bus.rs1_i) | ((ex_p0.rd == bus.rs2_i) & uses_rs2)) &
                  ~bus.flush_i;
  assign bubble = hazard | bus.flush_i | ~bus.valid_i;

  assign bus.stall_o        = hazard;
  assign bus.id_branch_o    = bus.valid_i & (bus.op_i == OP_BEQ) & ~bus.flush_i;
  assign bus.ex_valid_o     = vld_p0;
  assign bus.ex_aluop_o     = ex_p0.aluop;
  assign bus.ex_alusrc_o    = ex_p0.alusrc;
  assign bus.ex_illegal_o   = ex_p0.illegal;
  assign bus.mem_valid_o    = vld_p1;
  assign bus.mem_memread_o  = mem_p1.memread;
  assign bus.mem_memwrite_o = mem_p1.memwrite;
  assign bus.mem_regwrite_o = mem_p1.regwrite;
  assign bus.mem_rd_o       = mem_p1.rd;
  assign bus.wb_valid_o     = vld_p2;
  assign bus.wb_regwrite_o  = wb_p2.regwrite;
  assign bus.wb_memtoreg_o  = wb_p2.memtoreg;
  assign bus.wb_rd_o        = wb_p2.rd;
  assign bus.retired_o      = retired_q;
  assign bus.stalls_o       = stalls_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p0 <= 1'b0;
      ex_p0  <= '0;
      vld_p1 <= 1'b0;
      mem_p1 <= '0;
      vld_p2 <= 1'b0;
      wb_p2  <= '0;
    end else begin
      // ID -> EX (_p0)
      vld_p0 <= ~bubble;
      ex_p0  <= bubble ? '0 : dec;
      // EX -> MEM (_p1)
      vld_p1          <= vld_p0;
      mem_p1.regwrite <= ex_p0.regwrite;
      mem_p1.memread  <= ex_p0.memread;
      mem_p1.memwrite <= ex_p0.memwrite;
      mem_p1.memtoreg <= ex_p0.memtoreg;
      mem_p1.illegal  <= ex_p0.illegal;
      mem_p1.rd       <= ex_p0.rd;
      // MEM -> WB (_p2)
      vld_p2         <= vld_p1;
      wb_p2.regwrite <= mem_p1.regwrite;
      wb_p2.memtoreg <= mem_p1.memtoreg;
      wb_p2.illegal  <= mem_p1.illegal;
      wb_p2.rd       <= mem_p1.rd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retired_q <= '0;
      stalls_q  <= '0;
    end else if (bus.clr_cnt_i) begin
      retired_q <= '0;
      stalls_q  <= '0;
    end else begin
      retired_q <= sat_inc(retired_q, vld_p2 & ~wb_p2.illegal);
      stalls_q  <= sat_inc(stalls_q, hazard);
    end
  end
endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomised and directed stimulus for ctrl_pipe, scored against an
// instruction-history reference model through expectation queues.
module tb_ctrl_pipe;
  localparam int ALUOP_W = 2;
  localparam int RA_W    = 5;
  localparam int CNT_W   = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  localparam bit [6:0] R   = 7'b0110011;
  localparam bit [6:0] I   = 7'b0010011;
  localparam bit [6:0] LW  = 7'b0000011;
  localparam bit [6:0] SW  = 7'b0100011;
  localparam bit [6:0] BEQ = 7'b1100011;
  localparam bit [6:0] BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ctrl_pipe_if #(.ALUOP_W(ALUOP_W), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();
  ctrl_pipe #(.ALUOP_W(ALUOP_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [1:0] aluop;
    bit       alusrc, regwrite, memread, memwrite, memtoreg, illegal;
    bit [4:0] rd;
  } rec_t;
  typedef struct { bit stall; bit branch; } comb_t;
  typedef struct { rec_t ex; rec_t mem; rec_t wb; int ret; int stl; } snap_t;

  rec_t  hist[$];
  rec_t  wb_q[$];
  comb_t comb_q[$];
  snap_t snap_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    exp_ret = 0;
  int    exp_stl = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t bubble_rec();
    rec_t r;
    r = '{default: 0};
    return r;
  endfunction

  // Reference decode: table of opcode classes from the instruction set definition.
  function automatic rec_t decode(input bit [6:0] op, input bit [4:0] rd);
    rec_t r;
    r   = '{default: 0};
    r.v = 1'b1;
    case (op)
      R:   begin r.aluop = 2'b10; r.regwrite = 1'b1; end
      I:   begin r.aluop = 2'b11; r.alusrc = 1'b1; r.regwrite = 1'b1; end
      LW:  begin r.alusrc = 1'b1; r.regwrite = 1'b1; r.memread = 1'b1; r.memtoreg = 1'b1; end
      SW:  begin r.alusrc = 1'b1; r.memwrite = 1'b1; end
      BEQ: r.aluop = 2'b01;
      default: r.illegal = 1'b1;
    endcase
    if (r.regwrite) r.rd = rd;
    return r;
  endfunction

  function automatic int sat(input int c);
    return (c > MAXC) ? MAXC : c;
  endfunction

  function automatic void model_reset();
    hist.delete();
    wb_q.delete();
    for (int k = 0; k < 4; k++) hist.push_back(bubble_rec());
    exp_ret = 0;
    exp_stl = 0;
  endfunction

  // One ID slot, entered at a falling edge; returns whether the model expects a stall.
  task automatic issue(input bit [6:0] op, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [4:0] rd, input bit v, input bit fl, input bit clr,
                       output bit stalled);
    rec_t  ex_now, entering, src;
    comb_t c;
    snap_t s;
    bit    uses2;
    int    n;
    bus.op_i = op; bus.rs1_i = rs1; bus.rs2_i = rs2; bus.rd_i = rd;
    bus.valid_i = v; bus.flush_i = fl; bus.clr_cnt_i = clr;
    ex_now  = hist[hist.size()-1];
    uses2   = (op == R) || (op == SW) || (op == BEQ);
    c.stall = v && !fl && ex_now.v && ex_now.memread && (ex_now.rd != 0) &&
              ((ex_now.rd == rs1) || (uses2 && ex_now.rd == rs2));
    c.branch = v && !fl && (op == BEQ);
    comb_q.push_back(c);
    entering = (c.stall || fl || !v) ? bubble_rec() : decode(op, rd);
    hist.push_back(entering);
    if (entering.v) wb_q.push_back(entering);
    n   = hist.size();
    src = hist[n-4];
    if (clr) begin
      exp_ret = 0;
      exp_stl = 0;
    end else begin
      exp_ret = sat(exp_ret + ((src.v && !src.illegal) ? 1 : 0));
      exp_stl = sat(exp_stl + (c.stall ? 1 : 0));
    end
    s.ex = hist[n-1]; s.mem = hist[n-2]; s.wb = hist[n-3];
    s.ret = exp_ret; s.stl = exp_stl;
    snap_q.push_back(s);
    if (n > 8) void'(hist.pop_front());
    stalled = c.stall;
    @(negedge clk);
  endtask

  // Issue an instruction, re-presenting it while ID is held by a stall.
  task automatic go(input bit [6:0] op, input bit [4:0] rs1, input bit [4:0] rs2,
                    input bit [4:0] rd, input bit fl = 1'b0, input bit clr = 1'b0);
    bit st;
    issue(op, rs1, rs2, rd, 1'b1, fl, clr, st);
    for (int k = 0; k < 3 && st; k++) issue(op, rs1, rs2, rd, 1'b1, 1'b0, 1'b0, st);
  endtask

  task automatic idle(input int cycles, input bit clr = 1'b0);
    bit st;
    for (int k = 0; k < cycles; k++) issue(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, clr, st);
  endtask

  task automatic check_reset_outputs(input bit exp_branch);
    check("rst_stall_o", bus.stall_o, 0);
    check("rst_id_branch_o", bus.id_branch_o, exp_branch);
    check("rst_ex", {bus.ex_valid_o, bus.ex_aluop_o, bus.ex_alusrc_o, bus.ex_illegal_o}, 0);
    check("rst_mem", {bus.mem_valid_o, bus.mem_memread_o, bus.mem_memwrite_o,
                      bus.mem_regwrite_o, bus.mem_rd_o}, 0);
    check("rst_wb", {bus.wb_valid_o, bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_rd_o}, 0);
    check("rst_retired_o", bus.retired_o, 0);
    check("rst_stalls_o", bus.stalls_o, 0);
  endtask

  initial begin : comb_monitor
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && comb_q.size() > 0) begin
        c = comb_q.pop_front();
        check("stall_o", bus.stall_o, c.stall);
        check("id_branch_o", bus.id_branch_o, c.branch);
      end
    end
  end

  initial begin : reg_monitor
    snap_t s;
    rec_t  w;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && snap_q.size() > 0) begin
        s = snap_q.pop_front();
        check("ex_valid_o", bus.ex_valid_o, s.ex.v);
        check("ex_aluop_o", bus.ex_aluop_o, s.ex.aluop);
        check("ex_alusrc_o", bus.ex_alusrc_o, s.ex.alusrc);
        check("ex_illegal_o", bus.ex_illegal_o, s.ex.illegal);
        check("mem_valid_o", bus.mem_valid_o, s.mem.v);
        check("mem_memread_o", bus.mem_memread_o, s.mem.memread);
        check("mem_memwrite_o", bus.mem_memwrite_o, s.mem.memwrite);
        check("mem_regwrite_o", bus.mem_regwrite_o, s.mem.regwrite);
        check("mem_rd_o", bus.mem_rd_o, s.mem.rd);
        check("wb_valid_o", bus.wb_valid_o, s.wb.v);
        check("retired_o", bus.retired_o, s.ret);
        check("stalls_o", bus.stalls_o, s.stl);
      end
      if (mon_en && bus.wb_valid_o === 1'b1) begin
        check("wb_pending", wb_q.size() > 0, 1);
        if (wb_q.size() > 0) begin
          w = wb_q.pop_front();
          check("wb_regwrite_o", bus.wb_regwrite_o, w.regwrite);
          check("wb_memtoreg_o", bus.wb_memtoreg_o, w.memtoreg);
          check("wb_rd_o", bus.wb_rd_o, w.rd);
        end
      end
    end
  end

  initial begin : stimulus
    bit [6:0] op;
    bit       st;
    bus.op_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.clr_cnt_i = 1'b0;
    @(negedge clk);
    check_reset_outputs(1'b0);
    rst = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // back-to-back R then I
    go(R, 5'd1, 5'd2, 5'd3);
    go(I, 5'd1, 5'd2, 5'd4);
    idle(4);
    // load-use through rs2 of an R-type
    go(LW, 5'd1, 5'd2, 5'd5);
    go(R, 5'd6, 5'd5, 5'd7);
    idle(4);
    // no stall: load to x0, and I-type ignoring rs2
    go(LW, 5'd1, 5'd2, 5'd0);
    go(R, 5'd0, 5'd2, 5'd8);
    go(LW, 5'd1, 5'd2, 5'd5);
    go(I, 5'd6, 5'd5, 5'd9);
    idle(3);
    // flush beats both branch and load-use
    go(LW, 5'd1, 5'd2, 5'd5);
    go(BEQ, 5'd5, 5'd5, 5'd0, 1'b1);
    go(SW, 5'd5, 5'd3, 5'd4);
    idle(3);
    // illegal opcode
    go(BAD, 5'd1, 5'd2, 5'd9);
    go(BAD, 5'd5, 5'd5, 5'd5);
    idle(4);
    // drive both counters into saturation
    for (int k = 0; k < 20; k++) begin
      go(LW, 5'd2, 5'd3, 5'd1);
      go(R, 5'd1, 5'd4, 5'd6);
    end
    idle(4);
    go(BAD, 5'd1, 5'd1, 5'd1);
    go(LW, 5'd2, 5'd3, 5'd1);
    go(SW, 5'd1, 5'd1, 5'd1);
    idle(4);
    go(I, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    idle(4);
    go(LW, 5'd2, 5'd3, 5'd1);
    go(BEQ, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1);
    idle(4);

    // random traffic with small register indices to provoke hazards
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 5))
        0: op = R;
        1: op = I;
        2: op = LW;
        3: op = SW;
        4: op = BEQ;
        default: op = 7'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        issue(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, st);
        if (st) issue(op, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, st);
      end else begin
        go(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
      end
    end

    // asynchronous reset between edges with instructions in flight
    go(R, 5'd1, 5'd2, 5'd3);
    go(LW, 5'd1, 5'd2, 5'd5);
    go(I, 5'd1, 5'd2, 5'd4);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    bus.op_i = BEQ; bus.rs1_i = 5'd5; bus.rs2_i = 5'd5; bus.rd_i = 5'd0;
    bus.valid_i = 1'b1; bus.flush_i = 1'b0; bus.clr_cnt_i = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs(1'b1);
    @(posedge clk);
    #1;
    check_reset_outputs(1'b1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // pipeline restarts empty
    go(R, 5'd1, 5'd2, 5'd3);
    go(LW, 5'd1, 5'd2, 5'd5);
    go(SW, 5'd5, 5'd5, 5'd0);
    idle(5);

    @(posedge clk);
    #2;
    check("queues_drained", snap_q.size() + comb_q.size() + wb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
